// File: rtl/tile_vram_arbiter.sv
// rtl/tile_vram_arbiter.sv - tile VRAM arbiter for BG/SP fetchers and CPU bridge
// Round-robin BG/SP in active display, CPU in idle slots with starvation guard, CPU first in blanking.
module tile_vram_arbiter #(
  parameter int TILE_ADDR_W    = 20,
  parameter int TILE_DATA_W    = 8,
  parameter int CPU_STARVE_MAX = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   disp_active,
  input  logic                   bg_req,
  input  logic [TILE_ADDR_W-1:0] bg_addr,
  output logic                   bg_gnt,
  output logic                   bg_rvalid,
  output logic [TILE_DATA_W-1:0] bg_rdata,
  input  logic                   sp_req,
  input  logic [TILE_ADDR_W-1:0] sp_addr,
  output logic                   sp_gnt,
  output logic                   sp_rvalid,
  output logic [TILE_DATA_W-1:0] sp_rdata,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [TILE_ADDR_W-1:0] cpu_addr,
  input  logic [TILE_DATA_W-1:0] cpu_wdata,
  output logic                   cpu_gnt,
  output logic                   cpu_rvalid,
  output logic [TILE_DATA_W-1:0] cpu_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [TILE_ADDR_W-1:0] mem_addr,
  output logic [TILE_DATA_W-1:0] mem_wdata,
  input  logic [TILE_DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] STARVE_MAX = 8'(CPU_STARVE_MAX);
  localparam logic [1:0] ID_BG  = 2'd0;
  localparam logic [1:0] ID_SP  = 2'd1;
  localparam logic [1:0] ID_CPU = 2'd2;

  logic                   r_rr_ptr;
  logic [7:0]             r_starve_cnt;
  logic                   r_tag_valid;
  logic [1:0]             r_tag_id;
  logic                   r_bg_rvalid;
  logic                   r_sp_rvalid;
  logic                   r_cpu_rvalid;
  logic [TILE_DATA_W-1:0] r_bg_rdata;
  logic [TILE_DATA_W-1:0] r_sp_rdata;
  logic [TILE_DATA_W-1:0] r_cpu_rdata;

  logic                   w_force_cpu;
  logic                   w_bg_gnt;
  logic                   w_sp_gnt;
  logic                   w_cpu_gnt;
  logic                   w_rd_gnt;
  logic [1:0]             w_rd_id;

  assign w_force_cpu = (r_starve_cnt == STARVE_MAX);

  always_comb begin
    w_bg_gnt  = 1'b0;
    w_sp_gnt  = 1'b0;
    w_cpu_gnt = 1'b0;
    if (!rst) begin
      if (disp_active) begin
        // A starved CPU preempts both fetchers for exactly one slot
        if (w_force_cpu && cpu_req) begin
          w_cpu_gnt = 1'b1;
        end else if (bg_req && sp_req) begin
          w_bg_gnt = !r_rr_ptr;
          w_sp_gnt = r_rr_ptr;
        end else if (bg_req) begin
          w_bg_gnt = 1'b1;
        end else if (sp_req) begin
          w_sp_gnt = 1'b1;
        end else if (cpu_req) begin
          w_cpu_gnt = 1'b1;
        end
      end else begin
        if (cpu_req) begin
          w_cpu_gnt = 1'b1;
        end else if (bg_req) begin
          w_bg_gnt = 1'b1;
        end else if (sp_req) begin
          w_sp_gnt = 1'b1;
        end
      end
    end
  end

  assign bg_gnt  = w_bg_gnt;
  assign sp_gnt  = w_sp_gnt;
  assign cpu_gnt = w_cpu_gnt;
  assign mem_en  = w_bg_gnt | w_sp_gnt | w_cpu_gnt;
  assign mem_we  = w_cpu_gnt & cpu_we;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_bg_gnt) begin
      mem_addr = bg_addr;
    end else if (w_sp_gnt) begin
      mem_addr = sp_addr;
    end else if (w_cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_bg_gnt) begin
      r_rr_ptr <= 1'b1;
    end else if (w_sp_gnt) begin
      r_rr_ptr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !cpu_req || w_cpu_gnt) begin
      r_starve_cnt <= '0;
    end else if (disp_active && (r_starve_cnt != STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  assign w_rd_gnt = w_bg_gnt | w_sp_gnt | (w_cpu_gnt & !cpu_we);
  assign w_rd_id  = w_bg_gnt ? ID_BG : (w_sp_gnt ? ID_SP : ID_CPU);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_valid <= 1'b0;
      r_tag_id    <= ID_BG;
    end else begin
      r_tag_valid <= w_rd_gnt;
      r_tag_id    <= w_rd_id;
    end
  end

  // Only the tagged requester's data register loads; the others keep their last value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bg_rvalid  <= 1'b0;
      r_sp_rvalid  <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_bg_rdata   <= '0;
      r_sp_rdata   <= '0;
      r_cpu_rdata  <= '0;
    end else begin
      r_bg_rvalid  <= r_tag_valid && (r_tag_id == ID_BG);
      r_sp_rvalid  <= r_tag_valid && (r_tag_id == ID_SP);
      r_cpu_rvalid <= r_tag_valid && (r_tag_id == ID_CPU);
      if (r_tag_valid && (r_tag_id == ID_BG)) r_bg_rdata <= mem_rdata;
      if (r_tag_valid && (r_tag_id == ID_SP)) r_sp_rdata <= mem_rdata;
      if (r_tag_valid && (r_tag_id == ID_CPU)) r_cpu_rdata <= mem_rdata;
    end
  end

  assign bg_rvalid  = r_bg_rvalid;
  assign sp_rvalid  = r_sp_rvalid;
  assign cpu_rvalid = r_cpu_rvalid;
  assign bg_rdata   = r_bg_rdata;
  assign sp_rdata   = r_sp_rdata;
  assign cpu_rdata  = r_cpu_rdata;

endmodule

// File: tb/tb_tile_vram_arbiter.sv
// tb/tb_tile_vram_arbiter.sv - scoreboard bench for tile_vram_arbiter
module tb_tile_vram_arbiter;

  logic        clk;
  logic        rst;
  logic        disp_active;
  logic        bg_req, sp_req, cpu_req, cpu_we;
  logic [19:0] bg_addr, sp_addr, cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        bg_gnt, sp_gnt, cpu_gnt;
  logic        bg_rvalid, sp_rvalid, cpu_rvalid;
  logic [7:0]  bg_rdata, sp_rdata, cpu_rdata;
  logic        mem_en, mem_we;
  logic [19:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [2:0]  gnt;
    logic        we;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic        in_rst;
  } gexp_t;

  typedef struct {
    int         cyc;
    int         id;
    logic [7:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  tile_vram_arbiter #(.TILE_ADDR_W(20), .TILE_DATA_W(8), .CPU_STARVE_MAX(16)) dut (
    .clk(clk), .rst(rst), .disp_active(disp_active),
    .bg_req(bg_req), .bg_addr(bg_addr), .bg_gnt(bg_gnt), .bg_rvalid(bg_rvalid), .bg_rdata(bg_rdata),
    .sp_req(sp_req), .sp_addr(sp_addr), .sp_gnt(sp_gnt), .sp_rvalid(sp_rvalid), .sp_rdata(sp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data = addr[7:0], valid only the cycle after a read strobe
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr[7:0];
    else mem_rdata <= 8'h5A;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Apply one cycle of stimulus with its hand-computed grant vector {cpu,sp,bg}
  task automatic drive(input logic r, input logic d, input logic b, input logic s,
                       input logic c, input logic cw, input logic [2:0] eg, input logic ersp);
    gexp_t g;
    rexp_t x;
    rst = r; disp_active = d; bg_req = b; sp_req = s; cpu_req = c; cpu_we = cw;
    g.cyc = cyc; g.gnt = eg; g.we = eg[2] & cw; g.wdata = cpu_wdata; g.in_rst = r;
    g.addr = eg[0] ? bg_addr : (eg[1] ? sp_addr : (eg[2] ? cpu_addr : 20'h0));
    gq.push_back(g);
    if (ersp && (eg[0] || eg[1] || (eg[2] && !cw))) begin
      x.cyc  = cyc + 2;
      x.id   = eg[0] ? 0 : (eg[1] ? 1 : 2);
      x.data = g.addr[7:0];
      rq.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : grant_mon
    gexp_t g;
    if (gq.size() > 0 && gq[0].cyc == cyc) begin
      g = gq.pop_front();
      chk("gnt", {29'd0, cpu_gnt, sp_gnt, bg_gnt}, {29'd0, g.gnt});
      chk("mem_en", {31'd0, mem_en}, {31'd0, |g.gnt});
      chk("mem_we", {31'd0, mem_we}, {31'd0, g.we});
      if (g.gnt != 3'b000 || g.in_rst) chk("mem_addr", {12'd0, mem_addr}, {12'd0, g.addr});
      if (g.we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, g.wdata});
      if (g.in_rst) chk("mem_wdata_rst", {24'd0, mem_wdata}, 32'd0);
    end
  end

  always @(negedge clk) begin : rsp_mon
    rexp_t x;
    int nv;
    int id;
    logic [7:0] d;
    while (rq.size() > 0 && rq[0].cyc < cyc) begin
      x = rq.pop_front();
      checks++;
      errors++;
      $display("FAIL rsp_missing cycle=%0d actual=none expected=id%0d data %0h", x.cyc, x.id, x.data);
    end
    nv = int'(bg_rvalid) + int'(sp_rvalid) + int'(cpu_rvalid);
    if (nv > 1) begin
      chk("rvalid_onehot", nv, 1);
    end else if (nv == 1) begin
      id = bg_rvalid ? 0 : (sp_rvalid ? 1 : 2);
      d  = bg_rvalid ? bg_rdata : (sp_rvalid ? sp_rdata : cpu_rdata);
      if (rq.size() == 0 || rq[0].cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected cycle=%0d actual=id%0d data %0h expected=none", cyc, id, d);
      end else begin
        x = rq.pop_front();
        chk("rsp_id", id, x.id);
        chk("rsp_data", {24'd0, d}, {24'd0, x.data});
      end
    end
  end

  initial begin
    rst = 1'b1; disp_active = 1'b0;
    bg_req = 0; sp_req = 0; cpu_req = 0; cpu_we = 0;
    bg_addr = 0; sp_addr = 0; cpu_addr = 0; cpu_wdata = 0;
    @(posedge clk);
    #1;
    drive(1, 1, 1, 1, 0, 0, 3'b000, 0);
    drive(1, 1, 1, 1, 0, 0, 3'b000, 0);
    chk("rst_bg_rvalid", {31'd0, bg_rvalid}, 0);
    chk("rst_sp_rvalid", {31'd0, sp_rvalid}, 0);
    chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 0);

    // BG/SP contention alternates starting with BG
    bg_addr = 20'h00010; sp_addr = 20'h10020;
    for (int i = 0; i < 6; i++) drive(0, 1, 1, 1, 0, 0, (i % 2 == 1) ? 3'b010 : 3'b001, 1);

    // CPU starves 16 cycles, forced grant on the 17th, round-robin resumes with BG
    cpu_addr = 20'h00033;
    for (int i = 0; i < 16; i++) drive(0, 1, 1, 1, 1, 0, (i % 2 == 1) ? 3'b010 : 3'b001, 1);
    drive(0, 1, 1, 1, 1, 0, 3'b100, 1);
    drive(0, 1, 1, 1, 0, 0, 3'b001, 1);
    drive(0, 1, 1, 1, 0, 0, 3'b010, 1);

    // Blanking: CPU write first, then BG, then SP
    cpu_addr = 20'h00005; cpu_wdata = 8'hA5;
    drive(0, 0, 1, 1, 1, 1, 3'b100, 1);
    drive(0, 0, 1, 1, 0, 0, 3'b001, 1);
    drive(0, 0, 0, 1, 0, 0, 3'b010, 1);
    drive(0, 0, 0, 0, 0, 0, 3'b000, 0);

    // Back-to-back BG, SP, CPU reads
    bg_addr = 20'h0ABCD; sp_addr = 20'h2F0EE; cpu_addr = 20'h000C7; cpu_wdata = 8'h00;
    drive(0, 1, 1, 0, 0, 0, 3'b001, 1);
    drive(0, 1, 0, 1, 0, 0, 3'b010, 1);
    drive(0, 1, 0, 0, 1, 0, 3'b100, 1);
    drive(0, 1, 0, 0, 0, 0, 3'b000, 0);

    // Reset one cycle after an SP grant discards it and clears all outputs
    sp_addr = 20'h10020;
    drive(0, 1, 0, 1, 0, 0, 3'b010, 0);
    drive(1, 1, 1, 1, 0, 0, 3'b000, 0);
    chk("rst2_bg_rvalid", {31'd0, bg_rvalid}, 0);
    chk("rst2_sp_rvalid", {31'd0, sp_rvalid}, 0);
    chk("rst2_cpu_rvalid", {31'd0, cpu_rvalid}, 0);
    chk("rst2_bg_rdata", {24'd0, bg_rdata}, 0);
    chk("rst2_sp_rdata", {24'd0, sp_rdata}, 0);
    chk("rst2_cpu_rdata", {24'd0, cpu_rdata}, 0);
    chk("rst2_mem_en", {31'd0, mem_en}, 0);
    drive(0, 1, 1, 1, 0, 0, 3'b001, 0);
    // rr_ptr now points at SP; reset must return it to BG
    drive(1, 1, 1, 1, 0, 0, 3'b000, 0);
    drive(0, 1, 1, 1, 0, 0, 3'b001, 1);

    // SP alone is granted every cycle, then a contest goes to BG
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 1, 0, 0, 3'b010, 1);
    drive(0, 1, 1, 1, 0, 0, 3'b001, 1);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0, 3'b000, 0);

    chk("rsp_queue_empty", rq.size(), 0);
    chk("gnt_queue_empty", gq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_vram_arbiter.md
# tile_vram_arbiter

Shares the single-port tile VRAM (TILE_ADDR_W = 20-bit address, TILE_DATA_W = 8-bit data) among three requesters: background fetcher (BG), sprite fetcher (SP) and CPU bus bridge. BG and SP alternate round-robin during active display. The CPU is served in idle slots, with a starvation guard. During blanking the CPU has top priority. Sits between the renderer fetch units and the tile VRAM macro; the read-response path is tagged and pipelined so each requester receives only its own data.

## Interface
- TILE_ADDR_W, 20, tile memory address width (bank 4 + index 16)
- TILE_DATA_W, 8, tile memory data width
- CPU_STARVE_MAX, 16, active-display cycles a pending CPU request may wait before a forced grant (1..255)

- clk  in  1  system clock; one clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- disp_active  in  1  1 = visible pixel region, 0 = h/v blank
- bg_req, sp_req  in  1  read request (held until granted)
- bg_addr, sp_addr  in  TILE_ADDR_W  read address, stable while req=1
- bg_gnt, sp_gnt  out  1  request accepted this cycle
- bg_rvalid, sp_rvalid  out  1  read data valid (1-cycle pulse)
- bg_rdata, sp_rdata  out  TILE_DATA_W  read data
- cpu_req  in  1  access request (held until granted)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  TILE_ADDR_W  access address
- cpu_wdata  in  TILE_DATA_W  write data
- cpu_gnt  out  1  access accepted this cycle
- cpu_rvalid  out  1  read data valid (reads only)
- cpu_rdata  out  TILE_DATA_W  read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  TILE_ADDR_W  memory address
- mem_wdata  out  TILE_DATA_W  memory write data
- mem_rdata  in  TILE_DATA_W  memory read data, valid the cycle after mem_en & !mem_we

## Operation
- At most one grant per cycle; gnt outputs are one-hot or zero.
- mem_en = OR of grants; mem_addr, mem_we and mem_wdata are muxed from the granted requester. mem_we = cpu_gnt & cpu_we.
- Active display (disp_active=1):
  - Eligible set is {BG, SP} unless force_cpu is set.
  - If both BG and SP request, grant the one indicated by the rr_ptr register (0=BG, 1=SP). After any BG or SP grant, rr_ptr points to the other requester.
  - If only one requests, grant it. rr_ptr is updated the same way.
  - CPU is granted only when neither BG nor SP requests, or when force_cpu=1. force_cpu preempts BG and SP.
- Starvation counter starve_cnt (8 bit):
  - Increments each active-display cycle where cpu_req=1 and cpu_gnt=0, saturating at CPU_STARVE_MAX.
  - force_cpu = (starve_cnt == CPU_STARVE_MAX).
  - Clears on cpu_gnt, or when cpu_req=0.
  - Held (no increment) during blanking.
- Blanking (disp_active=0): priority CPU > BG > SP. rr_ptr is unchanged unless BG or SP is granted.
- Response tag pipeline:
  - Stage 1 latches {valid, id} of the granted read (id: 0=BG, 1=SP, 2=CPU). CPU writes produce no tag.
  - Stage 2 registers mem_rdata into the id-selected rdata register and pulses the matching rvalid.
  - Non-selected rdata registers hold their previous values.
- A disp_active change takes effect in the same cycle's arbitration. Responses already in flight complete unaffected.

## Timing
- Grants are combinational from the req inputs and the arbiter state. gnt is high in cycle N; mem_* are driven in cycle N.
- mem_rdata is valid in cycle N+1. The matching rvalid and rdata are registered, visible in N+2. Fixed read latency is 2 cycles, fully pipelined: one access per cycle sustained.
- A requester drops req, or presents its next request, in the cycle after gnt.
- Reset values:
  - All gnt outputs and mem_en = 0 while rst=1, regardless of req.
  - mem_we = 0; mem_addr and mem_wdata = 0.
  - rr_ptr = 0 (BG first); starve_cnt = 0.
  - Tag pipeline cleared; all rvalid = 0; all rdata = 0.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced for them.

## Test plan
- BG and SP both requesting continuously with disp_active=1 -> grants alternate BG,SP,BG,...; addresses 0x00010 (BG) and 0x10020 (SP) with memory model data = addr[7:0] -> bg_rdata=0x10 and sp_rdata=0x20, each 2 cycles after its grant.
- CPU read held with BG and SP saturating, CPU_STARVE_MAX=16 -> cpu_gnt exactly 16 cycles after first request (cycle 17); that cycle has no BG/SP grant; the round-robin sequence then resumes.
- disp_active=0 with all three requesting -> grant order CPU, then BG (once CPU drops), then SP; CPU write addr 0x00005, data 0xA5 -> mem_we=1 and mem_wdata=0xA5 in the grant cycle, no cpu_rvalid.
- Back-to-back reads BG,SP,CPU in consecutive cycles -> rvalid pulses bg, sp, cpu on consecutive cycles N+2..N+4, each carrying the correct data; no cross-routing.
- rst asserted one cycle after an SP read grant -> no sp_rvalid; all outputs 0; first post-reset contest between BG and SP grants BG.
- Single requester (SP only) during active display -> granted every cycle; rr_ptr ends at BG; starve_cnt stays 0 with cpu_req=0.
